subbytes_sched: RTL and testbench

SUBBYTES_SCHED -- requirements
Module: subbytes_sched

---
 rtl/subbytes_sched.sv | 118 +++++++++++
 tb/tb_subbytes_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_sched.sv
// Time-multiplexes one shared 32-bit SubBytes unit between 4-beat state jobs and 1-beat key jobs.
// Define SUBBYTES_SCHED_RR_EN for round-robin arbitration instead of fixed PRIO_KEY priority.
module subbytes_sched #(
  parameter bit PRIO_KEY = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_data,
  output logic         st_out_valid,
  output logic [127:0] st_out_data,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [31:0]  key_word,
  output logic         key_out_valid,
  output logic [31:0]  key_out_word,
  output logic [31:0]  sb_src,
  input  logic [31:0]  sb_result
);

  typedef enum logic [1:0] {IDLE, ST_ISSUE, KEY_ISSUE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [3:0][31:0]    data_q;
  logic [31:0]         key_q;
  logic                cap_vld_q, cap_key_q;
  logic [1:0]          cap_idx_q;
  logic [3:0][31:0]    st_out_q;
  logic [31:0]         key_out_q;
  logic                st_out_vld_q, key_out_vld_q;
  logic                idle, key_pri, key_acc, st_acc;

`ifdef SUBBYTES_SCHED_RR_EN
  logic rr_q;  // 1: key wins the next contended grant
  assign key_pri = rr_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                   rr_q <= 1'b1;
    else if (key_valid && st_valid && (key_acc || st_acc)) rr_q <= ~key_acc;
  end
`else
  assign key_pri = PRIO_KEY;
`endif

  assign idle      = (state_q == IDLE);
  assign key_ready = idle & reset_n & key_valid & (~st_valid | key_pri);
  assign st_ready  = idle & reset_n & st_valid & (~key_valid | ~key_pri);
  assign key_acc   = key_valid & key_ready;
  assign st_acc    = st_valid & st_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    sb_src  = 32'h0;
    case (state_q)
      IDLE: begin
        if (key_acc) state_d = KEY_ISSUE;
        else if (st_acc) begin
          state_d = ST_ISSUE;
          beat_d  = 2'd0;
        end
      end
      ST_ISSUE: begin
        sb_src = data_q[beat_q];
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = DRAIN;
      end
      KEY_ISSUE: begin
        sb_src  = key_q;
        state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are snapshotted at acceptance; the unit's result lags sb_src by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q        <= '0;
      key_q         <= '0;
      cap_vld_q     <= 1'b0;
      cap_key_q     <= 1'b0;
      cap_idx_q     <= 2'd0;
      st_out_q      <= '0;
      key_out_q     <= '0;
      st_out_vld_q  <= 1'b0;
      key_out_vld_q <= 1'b0;
    end else begin
      if (st_acc)  data_q <= st_data;
      if (key_acc) key_q  <= key_word;
      cap_vld_q     <= (state_q == ST_ISSUE) || (state_q == KEY_ISSUE);
      cap_key_q     <= (state_q == KEY_ISSUE);
      cap_idx_q     <= beat_q;
      if (cap_vld_q && cap_key_q)  key_out_q           <= sb_result;
      if (cap_vld_q && !cap_key_q) st_out_q[cap_idx_q] <= sb_result;
      st_out_vld_q  <= cap_vld_q && !cap_key_q && (cap_idx_q == 2'd3);
      key_out_vld_q <= cap_vld_q && cap_key_q;
    end
  end

  assign st_out_data   = st_out_q;
  assign st_out_valid  = st_out_vld_q;
  assign key_out_word  = key_out_q;
  assign key_out_valid = key_out_vld_q;

endmodule

// File: tb/tb_subbytes_sched.sv
// Directed bench for subbytes_sched with a behavioural registered AES S-box on the shared unit.
module tb_subbytes_sched;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         st_valid = 1'b0, key_valid = 1'b0;
  logic         st_ready, key_ready, st_out_valid, key_out_valid;
  logic [127:0] st_data = '0, st_out_data;
  logic [31:0]  key_word = '0, key_out_word, sb_src;
  logic [31:0]  sb_result = '0;

  int n_cmp = 0, n_fail = 0;

  subbytes_sched #(.PRIO_KEY(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .st_out_valid(st_out_valid), .st_out_data(st_out_data),
    .key_valid(key_valid), .key_ready(key_ready), .key_word(key_word),
    .key_out_valid(key_out_valid), .key_out_word(key_out_word),
    .sb_src(sb_src), .sb_result(sb_result)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sbox32(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  always @(posedge clock) sb_result <= sbox32(sb_src);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; #1;
    tick;
    reset_n = 1'b1;
  endtask

  // Starts in an idle cycle (#1 after an edge); ends #1 after the edge following the output pulse.
  task automatic run_job(input bit is_key, input logic [127:0] din, input logic [127:0] exp);
    logic [3:0][31:0] w;
    w = din;
    if (is_key) begin key_valid = 1'b1; key_word = din[31:0]; end
    else        begin st_valid  = 1'b1; st_data  = din;       end
    #1;
    chk(is_key ? "key_ready" : "st_ready", {127'h0, is_key ? key_ready : st_ready}, 128'h1);
    tick;
    key_valid = 1'b0; st_valid = 1'b0;
    key_word  = $urandom; st_data = {$urandom, $urandom, $urandom, $urandom};
    if (is_key) begin
      chk("key sb_src", {96'h0, sb_src}, {96'h0, din[31:0]});
      tick; chk("key_out_valid early", {127'h0, key_out_valid}, 128'h0);
      tick; chk("key_out_valid", {127'h0, key_out_valid}, 128'h1);
      chk("key_out_word", {96'h0, key_out_word}, {96'h0, exp[31:0]});
      tick; chk("key_out_valid pulse end", {127'h0, key_out_valid}, 128'h0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("st sb_src beat", {96'h0, sb_src}, {96'h0, w[k]});
        tick;
      end
      chk("drain sb_src", {96'h0, sb_src}, 128'h0);
      chk("st_out_valid early", {127'h0, st_out_valid}, 128'h0);
      tick; chk("st_out_valid", {127'h0, st_out_valid}, 128'h1);
      chk("st_out_data", st_out_data, exp);
      tick; chk("st_out_valid pulse end", {127'h0, st_out_valid}, 128'h0);
    end
  endtask

  typedef struct {
    bit           is_key;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[6];
  logic [127:0] last_st;
  logic [1:0]   grant;
  logic [1:0]   exp_grant[3];
  logic [31:0]  bb_in[3];
  logic [31:0]  bb_out[3];
  bit           found;

  initial begin
    vecs[0] = '{1'b0, 128'h0, {4{32'h63636363}}};
    vecs[1] = '{1'b1, {96'h0, 32'hcf4f3c09}, {96'h0, 32'h8a84eb01}};
    vecs[2] = '{1'b0, {32'h52525252, 32'hffffffff, 32'h01020304, 32'h000053ff},
                      {32'h00000000, 32'h16161616, 32'h7c777bf2, 32'h6363ed16}};
    vecs[3] = '{1'b1, {96'h0, 32'h00000000}, {96'h0, 32'h63636363}};
    vecs[4] = '{1'b1, {96'h0, 32'h01020304}, {96'h0, 32'h7c777bf2}};
    vecs[5] = '{1'b0, {32'hcf4f3c09, 32'h00000000, 32'h53535353, 32'h01020304},
                      {32'h8a84eb01, 32'h63636363, 32'hedededed, 32'h7c777bf2}};

    // Reset state, with a request pending
    st_valid = 1'b1; key_valid = 1'b1; #2;
    chk("rst st_ready", {127'h0, st_ready}, 128'h0);
    chk("rst key_ready", {127'h0, key_ready}, 128'h0);
    chk("rst sb_src", {96'h0, sb_src}, 128'h0);
    chk("rst outs", {st_out_data, key_out_word, st_out_valid, key_out_valid}, '0);
    st_valid = 1'b0; key_valid = 1'b0;
    tick; tick;
    reset_n = 1'b1;

    last_st = '0;
    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].is_key, vecs[i].din, vecs[i].exp);
      if (vecs[i].is_key) chk("st_out_data held", st_out_data, last_st);
      else last_st = vecs[i].exp;
    end

    // Reset in cycle A+3 of a state job discards it
    st_valid = 1'b1; st_data = {4{32'h01020304}}; #1;
    tick; st_valid = 1'b0;
    tick; tick;
    reset_n = 1'b0; #1;
    chk("midrst sb_src", {96'h0, sb_src}, 128'h0);
    chk("midrst outs", {st_out_data, key_out_word, st_out_valid, key_out_valid}, '0);
    chk("midrst readies", {126'h0, st_ready, key_ready}, 128'h0);
    for (int c = 0; c < 4; c++) begin
      tick; chk("midrst no st_out_valid", {127'h0, st_out_valid}, 128'h0);
    end
    reset_n = 1'b1;
    run_job(1'b1, 128'h0, {96'h0, 32'h63636363});
    chk("post-rst st_out_data", st_out_data, 128'h0);

    // Contention: key wins first, state served afterwards
    key_valid = 1'b1; key_word = 32'hcf4f3c09; st_valid = 1'b1; st_data = '0; #1;
    chk("contend key_ready", {127'h0, key_ready}, 128'h1);
    chk("contend st_ready", {127'h0, st_ready}, 128'h0);
    tick; key_valid = 1'b0;
    tick; tick;
    chk("contend key_out_valid", {127'h0, key_out_valid}, 128'h1);
    chk("contend key_out_word", {96'h0, key_out_word}, {96'h0, 32'h8a84eb01});
    chk("contend st_ready after", {127'h0, st_ready}, 128'h1);
    tick; st_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    chk("contend st_out_valid", {127'h0, st_out_valid}, 128'h1);
    chk("contend st_out_data", st_out_data, {4{32'h63636363}});
    tick;

    // Repeated contention: grant sequence
`ifdef SUBBYTES_SCHED_RR_EN
    exp_grant[0] = 2'b10; exp_grant[1] = 2'b01; exp_grant[2] = 2'b10;
`else
    exp_grant[0] = 2'b10; exp_grant[1] = 2'b10; exp_grant[2] = 2'b10;
`endif
    do_reset;
    key_valid = 1'b1; st_valid = 1'b1; key_word = 32'h11111111; st_data = '0; #1;
    for (int g = 0; g < 3; g++) begin
      found = 1'b0; grant = 2'b00;
      for (int c = 0; c < 12 && !found; c++) begin
        if (key_ready || st_ready) begin
          found = 1'b1; grant = {key_ready, st_ready};
        end else tick;
      end
      chk("grant seq", {126'h0, grant}, {126'h0, exp_grant[g]});
      tick;
    end
    key_valid = 1'b0; st_valid = 1'b0;
    for (int c = 0; c < 8; c++) tick;

    // Back-to-back key jobs with key_valid held high
    bb_in[0] = 32'h00000000; bb_out[0] = 32'h63636363;
    bb_in[1] = 32'hcf4f3c09; bb_out[1] = 32'h8a84eb01;
    bb_in[2] = 32'hffffffff; bb_out[2] = 32'h16161616;
    key_valid = 1'b1; key_word = bb_in[0]; #1;
    for (int i = 0; i < 3; i++) begin
      chk("b2b key_ready", {127'h0, key_ready}, 128'h1);
      tick;
      if (i < 2) key_word = bb_in[i+1];
      else key_valid = 1'b0;
      #1;
      chk("b2b sb_src", {96'h0, sb_src}, {96'h0, bb_in[i]});
      tick; chk("b2b no early pulse", {127'h0, key_out_valid}, 128'h0);
      tick; chk("b2b key_out_valid", {127'h0, key_out_valid}, 128'h1);
      chk("b2b key_out_word", {96'h0, key_out_word}, {96'h0, bb_out[i]});
      #1;
    end
    tick; chk("b2b pulse end", {127'h0, key_out_valid}, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
